uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_pkg.sv | 22 ++
 rtl/uart_cmd_parser_job_ram.sv | 22 ++
 rtl/uart_cmd_parser.sv | 192 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and FSM state type for the UART command parser.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  localparam logic [7:0] CMD_LOAD_JOB = 8'h01;
  localparam logic [7:0] CMD_START    = 8'h02;
  localparam logic [7:0] CMD_STOP     = 8'h03;
  localparam logic [7:0] CMD_PING     = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_RESP
  } state_t;

endpackage

// File: rtl/uart_cmd_parser_job_ram.sv
// Job buffer: single write port, registered read port; contents are not reset.
module job_ram #(
  parameter int DEPTH = 80,
  parameter int AW    = 7
) (
  input  logic          clk_hf,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk_hf) begin
    if (we && (int'(waddr) < DEPTH)) mem[waddr] <= wdata;
    if (int'(raddr) < DEPTH) rdata <= mem[raddr];
    else                     rdata <= 8'h00;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frame parser for A5/CMD/LEN/payload/CSUM commands with ACK/NAK replies.
// state      | meaning
// ST_IDLE    | hunting for SYNC
// ST_CMD     | expecting command byte
// ST_LEN     | expecting length byte
// ST_PAYLOAD | collecting payload bytes
// ST_CSUM    | expecting checksum byte
// ST_RESP    | waiting for transmitter to accept the reply
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int MAX_LEN        = 80,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk_hf,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       rx_error,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic [6:0] job_raddr,
  output logic [7:0] job_rdata,
  output logic [6:0] job_len,
  output logic       job_valid,
  output logic       job_load,
  output logic       mine_start,
  output logic       mine_stop,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, len_q, csum_q, resp_q, tx_hold_q;
  logic [6:0]    pay_idx;
  logic [TW-1:0] timer_q;
  logic          resp_pend;
  logic          byte_ok, in_frame, abort, resp_set, load_ok, start_ok, stop_ok, ram_we;
  logic [7:0]    resp_val;

  assign byte_ok  = rx_valid && !rx_error;
  assign in_frame = state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CSUM};
  // An rx_error in RESP cancels the reply even if the transmitter is free.
  assign tx_start = resp_pend && !tx_busy && !(state_q == ST_RESP && rx_error);
  assign tx_byte  = tx_start ? resp_q : tx_hold_q;

  always_comb begin
    state_d  = state_q;
    abort    = 1'b0;
    resp_set = 1'b0;
    resp_val = NAK;
    load_ok  = 1'b0;
    start_ok = 1'b0;
    stop_ok  = 1'b0;
    ram_we   = 1'b0;
    if (state_q != ST_IDLE && rx_error) begin
      abort   = 1'b1;
      state_d = ST_IDLE;
    end else if (in_frame && !rx_valid && timer_q == '0) begin
      abort   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (byte_ok && rx_byte == SYNC) state_d = ST_CMD;
        ST_CMD:     if (byte_ok) state_d = ST_LEN;
        ST_LEN: begin
          if (byte_ok) begin
            if (rx_byte > 8'(MAX_LEN)) begin
              resp_set = 1'b1;
              state_d  = ST_IDLE;
            end else if (rx_byte == 8'h00) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_ok) begin
            ram_we = (cmd_q == CMD_LOAD_JOB);
            if (({1'b0, pay_idx} + 8'd1) == len_q) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (byte_ok) begin
            state_d  = ST_RESP;
            resp_set = 1'b1;
            if (rx_byte == csum_q) begin
              case (cmd_q)
                CMD_LOAD_JOB: begin
                  load_ok  = 1'b1;
                  resp_val = ACK;
                end
                CMD_START: if (len_q == 8'h00 && job_valid) begin
                  start_ok = 1'b1;
                  resp_val = ACK;
                end
                CMD_STOP: if (len_q == 8'h00) begin
                  stop_ok  = 1'b1;
                  resp_val = ACK;
                end
                CMD_PING: if (len_q == 8'h00) resp_val = ACK;
                default: ;
              endcase
            end
          end
        end
        ST_RESP:    if (tx_start) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 8'h00;
      len_q      <= 8'h00;
      csum_q     <= 8'h00;
      resp_q     <= 8'h00;
      tx_hold_q  <= 8'h00;
      pay_idx    <= 7'd0;
      timer_q    <= TIMER_RELOAD;
      resp_pend  <= 1'b0;
      job_len    <= 7'd0;
      job_valid  <= 1'b0;
      job_load   <= 1'b0;
      mine_start <= 1'b0;
      mine_stop  <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      state_q    <= state_d;
      job_load   <= load_ok;
      mine_start <= start_ok;
      mine_stop  <= stop_ok;

      if (byte_ok)                         timer_q <= TIMER_RELOAD;
      else if (in_frame && timer_q != '0)  timer_q <= timer_q - TW'(1);

      if (byte_ok) begin
        case (state_q)
          ST_CMD: begin
            cmd_q  <= rx_byte;
            csum_q <= rx_byte;
          end
          ST_LEN: begin
            len_q   <= rx_byte;
            csum_q  <= csum_q ^ rx_byte;
            pay_idx <= 7'd0;
          end
          ST_PAYLOAD: begin
            csum_q  <= csum_q ^ rx_byte;
            pay_idx <= pay_idx + 7'd1;
          end
          default: ;
        endcase
      end

      if (tx_start) begin
        tx_hold_q <= resp_q;
        resp_pend <= 1'b0;
      end
      if (resp_set) begin
        resp_pend <= 1'b1;
        resp_q    <= resp_val;
      end else if (abort && state_q == ST_RESP) begin
        resp_pend <= 1'b0;
      end

      if (ram_we && pay_idx == 7'd0) job_valid <= 1'b0;
      if (load_ok) begin
        job_valid <= 1'b1;
        job_len   <= len_q[6:0];
      end

      if (abort && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  job_ram #(.DEPTH(MAX_LEN), .AW(7)) u_job_ram (
    .clk_hf (clk_hf),
    .we     (ram_we),
    .waddr  (pay_idx),
    .wdata  (rx_byte),
    .raddr  (job_raddr),
    .rdata  (job_rdata)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level reference model plus directed frames.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 80;
  localparam int TO      = 200;
  localparam logic [7:0] ACK_B = 8'h06;
  localparam logic [7:0] NAK_B = 8'h15;

  logic       clk_hf = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_error = 1'b0;
  logic       tx_busy = 1'b0;
  logic [6:0] job_raddr = 7'd0;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic [7:0] job_rdata;
  logic [6:0] job_len;
  logic       job_valid, job_load, mine_start, mine_stop;
  logic [7:0] err_count;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk_hf     (clk_hf),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .job_raddr  (job_raddr),
    .job_rdata  (job_rdata),
    .job_len    (job_len),
    .job_valid  (job_valid),
    .job_load   (job_load),
    .mine_start (mine_start),
    .mine_stop  (mine_stop),
    .err_count  (err_count)
  );

  always #5 clk_hf = ~clk_hf;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: tracks the frame as a byte list, decides at frame end.
  bit         m_active, m_wait, m_pend, m_job_valid, m_load, m_start, m_stop;
  logic [7:0] frame[$];
  logic [7:0] m_pend_byte, m_hold;
  int         m_silent, m_job_len, m_err;
  logic [7:0] m_mem [MAX_LEN];

  function automatic bit exp_tx_start();
    return m_pend && !tx_busy && !(m_wait && rx_error);
  endfunction

  function automatic void model_byte();
    int n;
    int len;
    logic [7:0] x;
    logic [7:0] r;
    n = frame.size();
    if (n == 2 && frame[1] > MAX_LEN) begin
      m_pend = 1'b1;
      m_pend_byte = NAK_B;
      m_active = 1'b0;
    end else if (n >= 3) begin
      len = int'(frame[1]);
      if (n <= len + 2) begin
        if (frame[0] == 8'h01) begin
          m_mem[n-3] = frame[n-1];
          if (n == 3) m_job_valid = 1'b0;
        end
      end else begin
        x = 8'h00;
        for (int i = 0; i < n - 1; i++) x = x ^ frame[i];
        r = NAK_B;
        if (x == frame[n-1]) begin
          if (frame[0] == 8'h01) begin
            m_job_valid = 1'b1; m_job_len = len; m_load = 1'b1; r = ACK_B;
          end else if (frame[0] == 8'h02 && len == 0 && m_job_valid) begin
            m_start = 1'b1; r = ACK_B;
          end else if (frame[0] == 8'h03 && len == 0) begin
            m_stop = 1'b1; r = ACK_B;
          end else if (frame[0] == 8'h04 && len == 0) begin
            r = ACK_B;
          end
        end
        m_pend = 1'b1;
        m_pend_byte = r;
        m_active = 1'b0;
        m_wait = 1'b1;
      end
    end
  endfunction

  always @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      m_active = 0; m_wait = 0; m_pend = 0; m_job_valid = 0;
      m_load = 0; m_start = 0; m_stop = 0;
      m_pend_byte = 8'h00; m_hold = 8'h00;
      m_silent = 0; m_job_len = 0; m_err = 0;
      frame.delete();
    end else begin : step
      bit ts;
      ts = exp_tx_start();
      m_load = 0; m_start = 0; m_stop = 0;
      if (ts) begin
        m_hold = m_pend_byte;
        m_pend = 1'b0;
      end
      if ((m_active || m_wait) && rx_error) begin
        if (m_err < 255) m_err++;
        if (m_wait) m_pend = 1'b0;
        m_active = 1'b0;
        m_wait = 1'b0;
      end else if (m_active && !rx_valid) begin
        m_silent++;
        if (m_silent == TO) begin
          if (m_err < 255) m_err++;
          m_active = 1'b0;
        end
      end else if (m_wait) begin
        if (ts) m_wait = 1'b0;
      end else if (rx_valid && !rx_error) begin
        if (!m_active) begin
          if (rx_byte == 8'hA5) begin
            m_active = 1'b1;
            m_silent = 0;
            frame.delete();
          end
        end else begin
          m_silent = 0;
          frame.push_back(rx_byte);
          model_byte();
        end
      end
    end
  end

  int         cyc = 0;
  int         tx_cyc = 0;
  int         n_start = 0, n_stop = 0, n_load = 0;
  logic [7:0] tx_log[$];

  always @(negedge clk_hf) begin
    if (!reset) begin
      cyc++;
      chk("tx_start", int'(tx_start), int'(exp_tx_start()));
      chk("tx_byte", int'(tx_byte), int'(exp_tx_start() ? m_pend_byte : m_hold));
      chk("job_len", int'(job_len), m_job_len);
      chk("job_valid", int'(job_valid), int'(m_job_valid));
      chk("job_load", int'(job_load), int'(m_load));
      chk("mine_start", int'(mine_start), int'(m_start));
      chk("mine_stop", int'(mine_stop), int'(m_stop));
      chk("err_count", int'(err_count), m_err);
      if (tx_start) begin
        tx_log.push_back(tx_byte);
        tx_cyc = cyc;
      end
      if (mine_start) n_start++;
      if (mine_stop)  n_stop++;
      if (job_load)   n_load++;
    end
  end

  // Stimulus helpers; every task leaves time at 1 ns past a rising edge.
  logic [7:0] fr[$];
  int         tx_rd = 0;
  int         s0, p0, l0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_hf);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick(1);
    rx_valid = 1'b0;
    tick(2);
  endtask

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
    tick(4);
  endtask

  task automatic mark();
    s0 = n_start; p0 = n_stop; l0 = n_load;
  endtask

  task automatic expect_tx(input string name, input int exp_n, input logic [7:0] exp_b);
    int n;
    n = tx_log.size() - tx_rd;
    chk({name, " tx count"}, n, exp_n);
    if (n > 0 && exp_n > 0) chk({name, " tx byte"}, int'(tx_log[tx_rd]), int'(exp_b));
    tx_rd = tx_log.size();
  endtask

  logic [7:0] exp_pay [3];

  initial begin
    exp_pay[0] = 8'h11; exp_pay[1] = 8'h22; exp_pay[2] = 8'h33;
    tick(3);
    chk("reset tx_start", int'(tx_start), 0);
    chk("reset tx_byte", int'(tx_byte), 0);
    chk("reset job_len", int'(job_len), 0);
    chk("reset job_valid", int'(job_valid), 0);
    chk("reset job_load", int'(job_load), 0);
    chk("reset mine_start", int'(mine_start), 0);
    chk("reset mine_stop", int'(mine_stop), 0);
    chk("reset err_count", int'(err_count), 0);
    reset = 1'b0;
    tick(2);

    mark();
    fr = {8'hA5, 8'h04, 8'h00, 8'h04};
    send_fr();
    expect_tx("ping", 1, ACK_B);
    chk("ping pulses", (n_start - s0) + (n_stop - p0) + (n_load - l0), 0);

    mark();
    fr = {8'hA5, 8'h02, 8'h00, 8'h02};
    send_fr();
    expect_tx("start no job", 1, NAK_B);
    chk("start no job mine_start", n_start - s0, 0);

    // checksum of 01 03 11 22 33 is 0x02
    mark();
    fr = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02};
    send_fr();
    expect_tx("load", 1, ACK_B);
    chk("load job_load pulses", n_load - l0, 1);
    chk("load job_len", int'(job_len), 3);
    chk("load job_valid", int'(job_valid), 1);
    for (int i = 0; i < 3; i++) begin
      job_raddr = 7'(i);
      tick(1);
      chk("job_rdata", int'(job_rdata), int'(exp_pay[i]));
    end

    mark();
    fr = {8'hA5, 8'h02, 8'h00, 8'h03};
    send_fr();
    expect_tx("bad csum", 1, NAK_B);
    chk("bad csum mine_start", n_start - s0, 0);
    chk("bad csum err_count", int'(err_count), 0);

    mark();
    fr = {8'hA5, 8'h02, 8'h00, 8'h02};
    send_fr();
    expect_tx("start", 1, ACK_B);
    chk("start mine_start pulses", n_start - s0, 1);

    mark();
    fr = {8'hA5, 8'h03, 8'h00, 8'h03};
    send_fr();
    expect_tx("stop", 1, ACK_B);
    chk("stop mine_stop pulses", n_stop - p0, 1);

    fr = {8'hA5, 8'h04, 8'h01, 8'h55, 8'h50};
    send_fr();
    expect_tx("ping with payload", 1, NAK_B);

    fr = {8'hA5, 8'h09, 8'h00, 8'h09};
    send_fr();
    expect_tx("unknown cmd", 1, NAK_B);

    fr = {8'hA5, 8'h01, 8'h51};
    send_fr();
    expect_tx("len too long", 1, NAK_B);
    chk("len too long job_valid", int'(job_valid), 1);

    mark();
    fr = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send_fr();
    expect_tx("load bad csum", 1, NAK_B);
    chk("load bad csum job_valid", int'(job_valid), 0);
    chk("load bad csum job_load", n_load - l0, 0);

    fr = {8'hA5, 8'h02, 8'h00, 8'h02};
    send_fr();
    expect_tx("start after bad load", 1, NAK_B);

    fr = {8'hA5, 8'h01, 8'h05};
    send_fr();
    tick(TO + 10);
    chk("timeout err_count", int'(err_count), 1);
    expect_tx("timeout", 0, 8'h00);
    fr = {8'hA5, 8'h04, 8'h00, 8'h04};
    send_fr();
    expect_tx("ping after timeout", 1, ACK_B);

    send(8'hA5);
    send(8'h04);
    rx_valid = 1'b1; rx_error = 1'b1; rx_byte = 8'h00;
    tick(1);
    rx_valid = 1'b0; rx_error = 1'b0;
    tick(2);
    send(8'h04);
    tick(4);
    chk("rx_error priority err_count", int'(err_count), 2);
    expect_tx("rx_error abort", 0, 8'h00);

    send(8'hA5); send(8'h04); send(8'h00);
    tx_busy = 1'b1;
    send(8'h04);
    fr = {8'hA5, 8'h04, 8'h00, 8'h04};
    send_fr();
    tick(500 - 15);
    chk("busy no early tx", tx_log.size() - tx_rd, 0);
    tx_busy = 1'b0;
    s0 = cyc + 1;
    tick(5);
    expect_tx("busy release", 1, ACK_B);
    chk("busy tx_start cycle", tx_cyc, s0);

    repeat (300) begin
      send(8'hA5);
      rx_error = 1'b1;
      tick(1);
      rx_error = 1'b0;
      tick(1);
    end
    chk("err_count saturated", int'(err_count), 255);
    expect_tx("error frames", 0, 8'h00);

    send(8'hA5);
    send(8'h04);
    reset = 1'b1;
    tick(1);
    chk("mid-frame reset err_count", int'(err_count), 0);
    reset = 1'b0;
    tick(1);
    send(8'h00);
    send(8'h04);
    tick(4);
    expect_tx("mid-frame reset", 0, 8'h00);
    fr = {8'hA5, 8'h04, 8'h00, 8'h04};
    send_fr();
    expect_tx("ping after reset", 1, ACK_B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
